// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode-side stall and
// resume signals, and execute-side redirect.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_stall;
    logic        dmem_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_f;
    logic [31:0] pc_f;
    logic        inst_valid_f;
    logic        branch_resume;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, inst_f, pc_f, inst_valid_f, branch_resume,
        input  imem_ack, imem_rdata, branch_stall, dmem_stall, redirect_valid, redirect_pc
    );

    // Memory / decode / execute side
    modport slave (
        input  imem_req, imem_addr, inst_f, pc_f, inst_valid_f, branch_resume,
        output imem_ack, imem_rdata, branch_stall, dmem_stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches to instruction
// memory, holds one word across decode stalls, and applies execute redirects
// (draining a response that was already in flight when the redirect hit).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      state_r, state_nx_s;
    logic [31:0] pc_r, pc_nx_s;
    logic        pending_r, pending_nx_s;
    logic [31:0] req_addr_r, req_addr_nx_s;
    logic        hold_valid_r, hold_valid_nx_s;
    logic [31:0] hold_inst_r, hold_inst_nx_s;
    logic [31:0] hold_pc_r, hold_pc_nx_s;
    logic [31:0] inst_f_r, inst_f_nx_s;
    logic [31:0] pc_f_r, pc_f_nx_s;
    logic        inst_valid_r, inst_valid_nx_s;
    logic        resume_r, resume_nx_s;

    logic        stall_any_s;
    logic        req_s;
    logic        ack_s;
    logic [31:0] addr_s;
    logic [31:0] redirect_tgt_s;

    // Request/address generation: a started request is never withdrawn, and a
    // new one only starts while running with an empty hold and no stall.
    always_comb begin
        stall_any_s    = bus.branch_stall | bus.dmem_stall;
        req_s          = pending_r | ((state_r == ST_RUN) & ~hold_valid_r & ~stall_any_s & ~rst);
        addr_s         = pending_r ? req_addr_r : pc_r;
        ack_s          = req_s & bus.imem_ack;
        redirect_tgt_s = bus.redirect_pc & 32'hFFFF_FFFC;
    end

    assign bus.imem_req      = req_s;
    assign bus.imem_addr     = addr_s;
    assign bus.inst_f        = inst_f_r;
    assign bus.pc_f          = pc_f_r;
    assign bus.inst_valid_f  = inst_valid_r;
    assign bus.branch_resume = resume_r;

    // Next-state and next-output logic; a bubble is the default every cycle.
    always_comb begin
        state_nx_s      = state_r;
        pc_nx_s         = pc_r;
        hold_valid_nx_s = hold_valid_r;
        hold_inst_nx_s  = hold_inst_r;
        hold_pc_nx_s    = hold_pc_r;
        inst_f_nx_s     = NOP_INST;
        pc_f_nx_s       = pc_f_r;
        inst_valid_nx_s = 1'b0;
        resume_nx_s     = 1'b0;
        req_addr_nx_s   = req_addr_r;
        pending_nx_s    = pending_r;

        // Latch the address on the first cycle of a request.
        if (req_s && !pending_r) begin
            req_addr_nx_s = pc_r;
        end else begin
            req_addr_nx_s = req_addr_r;
        end

        if (req_s && !bus.imem_ack) begin
            pending_nx_s = 1'b1;
        end else if (ack_s) begin
            pending_nx_s = 1'b0;
        end else begin
            pending_nx_s = pending_r;
        end

        case (state_r)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    // Redirect wins over ack, stall and hold; an ack in the
                    // same cycle is simply dropped.
                    pc_nx_s         = redirect_tgt_s;
                    hold_valid_nx_s = 1'b0;
                    resume_nx_s     = 1'b1;
                    if (req_s && !bus.imem_ack) begin
                        state_nx_s = ST_DRAIN;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else if (ack_s) begin
                    pc_nx_s = addr_s + 32'd4;
                    if (stall_any_s) begin
                        hold_valid_nx_s = 1'b1;
                        hold_inst_nx_s  = bus.imem_rdata;
                        hold_pc_nx_s    = addr_s;
                    end else begin
                        inst_f_nx_s     = bus.imem_rdata;
                        pc_f_nx_s       = addr_s;
                        inst_valid_nx_s = 1'b1;
                    end
                end else if (hold_valid_r && !stall_any_s) begin
                    inst_f_nx_s     = hold_inst_r;
                    pc_f_nx_s       = hold_pc_r;
                    inst_valid_nx_s = 1'b1;
                    hold_valid_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // The outstanding response belongs to the old path and is
                // discarded; a further redirect just retargets the PC.
                if (bus.redirect_valid) begin
                    pc_nx_s     = redirect_tgt_s;
                    resume_nx_s = 1'b1;
                end else begin
                    pc_nx_s = pc_r;
                end
                if (ack_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_PC;
            pending_r    <= 1'b0;
            req_addr_r   <= RESET_PC;
            hold_valid_r <= 1'b0;
            hold_inst_r  <= NOP_INST;
            hold_pc_r    <= 32'h0000_0000;
            inst_f_r     <= NOP_INST;
            pc_f_r       <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
            resume_r     <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            pc_r         <= pc_nx_s;
            pending_r    <= pending_nx_s;
            req_addr_r   <= req_addr_nx_s;
            hold_valid_r <= hold_valid_nx_s;
            hold_inst_r  <= hold_inst_nx_s;
            hold_pc_r    <= hold_pc_nx_s;
            inst_f_r     <= inst_f_nx_s;
            pc_f_r       <= pc_f_nx_s;
            inst_valid_r <= inst_valid_nx_s;
            resume_r     <= resume_nx_s;
        end
    end
endmodule
